// File: rtl/output_arbiter.sv
// Output-buffer arbiter: CPU writes take priority over an autonomous
// display scan that reads, captures and dwells on each buffer word.
module output_arbiter (
  input  logic        clock,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [4:0]  cpu_adress,
  input  logic [31:0] cpu_writedata,
  output logic        cpu_ack,
  input  logic        scan_en,
  input  logic [4:0]  scan_last,
  input  logic [7:0]  dwell,
  output logic [4:0]  mem_adress,
  output logic [31:0] mem_writedata,
  output logic        mem_MemWrite,
  output logic        mem_out,
  output logic        mem_rst,
  input  logic [31:0] buf_dataout,
  output logic [31:0] disp_data,
  output logic [4:0]  disp_index,
  output logic        disp_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_DWELL,
    S_CLEAR
  } state_e;

  state_e      state_q, state_d;
  logic        ret_dwell_q, ret_dwell_d;
  logic        scanning_q, scanning_d;
  logic [4:0]  ptr_q, ptr_d, ptr_nxt;
  logic [7:0]  cnt_q, cnt_d, cnt_dec;
  logic [31:0] data_q, data_d;
  logic [4:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        ack_q, mw_q, rd_q, clr_q;
  logic [4:0]  adr_q;
  logic [31:0] wdata_q;
  logic        scan_act;

  assign scan_act = scan_en && (scan_last != 5'd0);
  assign ptr_nxt  = (ptr_q >= scan_last) ? 5'd1 : ptr_q + 5'd1;
  assign cnt_dec  = cnt_q - 8'd1;

  always_comb begin
    state_d     = state_q;
    ret_dwell_d = ret_dwell_q;
    scanning_d  = scanning_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    idx_d       = idx_q;
    valid_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          state_d     = S_WRITE;
          ret_dwell_d = 1'b0;
        end else if (scan_act) begin
          state_d    = S_READ;
          scanning_d = 1'b1;
        end else if (scanning_q) begin
          state_d = S_CLEAR;
        end
      end
      S_WRITE: begin
        // a write taken from IDLE hands straight over to a pending scan
        if (ret_dwell_q) begin
          state_d = S_DWELL;
        end else if (scan_act) begin
          state_d    = S_READ;
          scanning_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = buf_dataout;
        idx_d   = ptr_q;
        valid_d = 1'b1;
        if (dwell == 8'd0) begin
          ptr_d   = ptr_nxt;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = dwell;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cpu_req) begin
          cnt_d   = cnt_dec;
          state_d = S_WRITE;
          if (cnt_dec == 8'd0) begin
            ptr_d       = ptr_nxt;
            ret_dwell_d = 1'b0;
          end else begin
            ret_dwell_d = 1'b1;
          end
        end else if (!scan_en) begin
          state_d = S_CLEAR;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == 8'd0) begin
            ptr_d   = ptr_nxt;
            state_d = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        data_d     = 32'd0;
        idx_d      = 5'd0;
        ptr_d      = 5'd1;
        cnt_d      = 8'd0;
        scanning_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ret_dwell_q <= 1'b0;
      scanning_q  <= 1'b0;
      ptr_q       <= 5'd1;
      cnt_q       <= 8'd0;
      data_q      <= 32'd0;
      idx_q       <= 5'd0;
      valid_q     <= 1'b0;
      ack_q       <= 1'b0;
      mw_q        <= 1'b0;
      rd_q        <= 1'b0;
      clr_q       <= 1'b0;
      adr_q       <= 5'd0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      ret_dwell_q <= ret_dwell_d;
      scanning_q  <= scanning_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      ack_q       <= (state_d == S_WRITE);
      // word 0 is hardwired zero, so its write is acked but never strobed
      mw_q        <= (state_d == S_WRITE) && (cpu_adress != 5'd0);
      rd_q        <= (state_d == S_READ);
      clr_q       <= (state_d == S_CLEAR);
      if (state_d == S_WRITE) begin
        adr_q   <= cpu_adress;
        wdata_q <= cpu_writedata;
      end else if (state_d == S_READ) begin
        adr_q   <= ptr_d;
        wdata_q <= 32'd0;
      end else begin
        adr_q   <= 5'd0;
        wdata_q <= 32'd0;
      end
    end
  end

  assign cpu_ack       = ack_q & ~rst;
  assign mem_MemWrite  = mw_q & ~rst;
  assign mem_out       = rd_q & ~rst;
  assign mem_rst       = clr_q | rst;
  assign mem_adress    = adr_q;
  assign mem_writedata = wdata_q;
  assign disp_data     = data_q;
  assign disp_index    = idx_q;
  assign disp_valid    = valid_q & ~rst;
  assign busy          = (state_q != S_IDLE);

endmodule
